// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the IF/LS single-port memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } requester_t;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_DATA_WIDTH = 64;
    // Wide enough for MEM_LAT up to 7.
    localparam int CNT_WIDTH      = 3;

    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int BYTE_OFF_BITS = byte_off_bits(DEF_DATA_WIDTH);

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and RAM-side signal bundle of the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_data;
    logic                  if_resp_error;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_resp_valid;
    logic [DATA_WIDTH-1:0] ls_resp_data;
    logic                  ls_resp_error;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_error;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_we, ls_addr, ls_wdata,
        input  mem_rdata, mem_error,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_error,
        output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_error,
        output mem_addr, mem_wdata, mem_we
    );

    // Requesters and RAM side.
    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_we, ls_addr, ls_wdata,
        output mem_rdata, mem_error,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_error,
        input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_error,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-input round-robin grant with last-grant memory
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);

    requester_t last_grant;

    // On a tie the requester not served last wins; reset leaves IF as last so LS wins first.
    assign gnt_ls = req_ls & (~req_if | (last_grant == REQ_IF));
    assign gnt_if = req_if & ~gnt_ls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_IF;
        end else if (en && (gnt_if || gnt_ls)) begin
            last_grant <= gnt_ls ? REQ_LS : REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM read/write port between instruction fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int                    OFF_BITS = byte_off_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [CNT_WIDTH-1:0]  LAT_M1   = CNT_WIDTH'(MEM_LAT - 1);

    state_t                state;
    state_t                state_n;
    requester_t            gnt_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  we_q;
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  arb_en;
    logic                  gnt_if;
    logic                  gnt_ls;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_mis;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    logic                  if_resp_valid_q;
    logic [DATA_WIDTH-1:0] if_resp_data_q;
    logic                  if_resp_error_q;
    logic                  ls_resp_valid_q;
    logic [DATA_WIDTH-1:0] ls_resp_data_q;
    logic                  ls_resp_error_q;

    assign arb_en = (state == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (reset),
        .en     (arb_en),
        .req_if (bus.if_req_valid),
        .req_ls (bus.ls_req_valid),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    assign hs       = arb_en & (gnt_if | gnt_ls);
    assign sel_addr = gnt_ls ? bus.ls_addr : bus.if_addr;
    assign sel_mis  = (sel_addr & OFF_MASK) != '0;

    // Ready is gated by reset so nothing looks accepted while the block is held in reset.
    assign bus.if_req_ready = reset & arb_en & gnt_if;
    assign bus.ls_req_ready = reset & arb_en & gnt_ls;

    // Misaligned requests and stores report zero data; misaligned ones never reach RAM.
    assign resp_data = (mis_q | we_q) ? '0 : bus.mem_rdata;
    assign resp_err  = mis_q | bus.mem_error;

    always_comb begin
        state_n  = state;
        mem_we_c = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_n = sel_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_we_c = we_q;
                state_n  = (MEM_LAT > 1) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt_q   <= REQ_IF;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (hs) begin
                        gnt_q <= gnt_ls ? REQ_LS : REQ_IF;
                        we_q  <= gnt_ls & bus.ls_we;
                        mis_q <= sel_mis;
                        // The RAM address only moves for accesses that will actually be issued.
                        if (!sel_mis) begin
                            addr_q <= sel_addr;
                            if (gnt_ls) begin
                                wdata_q <= bus.ls_wdata;
                            end
                        end
                    end
                end
                ACCESS: cnt <= LAT_M1;
                WAIT:   cnt <= cnt - CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            if_resp_error_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_data_q  <= '0;
            ls_resp_error_q <= 1'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if (state == RESP) begin
                if (gnt_q == REQ_LS) begin
                    ls_resp_valid_q <= 1'b1;
                    ls_resp_data_q  <= resp_data;
                    ls_resp_error_q <= resp_err;
                end else begin
                    if_resp_valid_q <= 1'b1;
                    if_resp_data_q  <= resp_data;
                    if_resp_error_q <= resp_err;
                end
            end
        end
    end

    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_we        = mem_we_c;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_data  = if_resp_data_q;
    assign bus.if_resp_error = if_resp_error_q;
    assign bus.ls_resp_valid = ls_resp_valid_q;
    assign bus.ls_resp_data  = ls_resp_data_q;
    assign bus.ls_resp_error = ls_resp_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at MEM_LAT 1 and 3
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset1;
    logic reset3;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) b1 ();
    mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) b3 ();

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (b1)
    );

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (b3)
    );

    // RAM models: 2048 words, out-of-range addresses report an error and read 0.
    logic [63:0] mem1 [0:2047];
    logic [63:0] mem3 [0:2047];
    logic [63:0] rd1;
    logic        er1;
    logic [63:0] rd3 [0:2];
    logic        er3 [0:2];

    function automatic logic in_range(input logic [63:0] a);
        return a[63:14] == 50'd0;
    endfunction

    always @(posedge clk) begin
        if (b1.mem_we && in_range(b1.mem_addr)) mem1[b1.mem_addr[13:3]] <= b1.mem_wdata;
        rd1 <= in_range(b1.mem_addr) ? mem1[b1.mem_addr[13:3]] : 64'd0;
        er1 <= !in_range(b1.mem_addr);
    end
    assign b1.mem_rdata = rd1;
    assign b1.mem_error = er1;

    always @(posedge clk) begin
        if (b3.mem_we && in_range(b3.mem_addr)) mem3[b3.mem_addr[13:3]] <= b3.mem_wdata;
        rd3[0] <= in_range(b3.mem_addr) ? mem3[b3.mem_addr[13:3]] : 64'd0;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
        er3[0] <= !in_range(b3.mem_addr);
        er3[1] <= er3[0];
        er3[2] <= er3[1];
    end
    assign b3.mem_rdata = rd3[2];
    assign b3.mem_error = er3[2];

    int we1;
    int if_resp1;
    int ls_resp1;
    always @(negedge clk) begin
        if (b1.mem_we)        we1      <= we1 + 1;
        if (b1.if_resp_valid) if_resp1 <= if_resp1 + 1;
        if (b1.ls_resp_valid) ls_resp1 <= ls_resp1 + 1;
    end

    int checks;
    int errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic txn(input bit is_ls, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic [63:0] rdata,
                       output logic err, output int lat);
        bit ok;
        @(posedge clk);
        #1;
        if (is_ls) begin
            b1.ls_req_valid = 1'b1;
            b1.ls_we        = we;
            b1.ls_addr      = addr;
            b1.ls_wdata     = wdata;
        end else begin
            b1.if_req_valid = 1'b1;
            b1.if_addr      = addr;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = is_ls ? b1.ls_req_ready : b1.if_req_ready;
        end
        check("req_ready_seen", ok, 1);
        @(posedge clk);
        #1;
        b1.ls_req_valid = 1'b0;
        b1.if_req_valid = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = is_ls ? b1.ls_resp_valid : b1.if_resp_valid;
            if (!ok) begin
                @(posedge clk);
                lat++;
            end
        end
        check("resp_seen", ok, 1);
        check("other_resp_idle", is_ls ? b1.if_resp_valid : b1.ls_resp_valid, 0);
        rdata = is_ls ? b1.ls_resp_data  : b1.if_resp_data;
        err   = is_ls ? b1.ls_resp_error : b1.if_resp_error;
        @(negedge clk);
        check("resp_pulse", is_ls ? b1.ls_resp_valid : b1.if_resp_valid, 0);
    endtask

    logic [63:0] d;
    logic        e;
    int          lat;
    int          w0;
    int          ri0;
    int          rl0;
    int          n;
    int          both;
    int          bad;
    bit          ok;
    bit          seen;
    bit          dropped;
    logic [7:0]  gseq;
    logic        bulk_err;

    initial begin
        checks = 0;
        errors = 0;
        reset1 = 1'b0;
        reset3 = 1'b0;
        b1.if_req_valid = 1'b1; b1.if_addr = 64'h80;
        b1.ls_req_valid = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 64'h40; b1.ls_wdata = 64'd0;
        b3.if_req_valid = 1'b0; b3.if_addr = 64'd0;
        b3.ls_req_valid = 1'b0; b3.ls_we = 1'b0; b3.ls_addr = 64'd0; b3.ls_wdata = 64'd0;

        // Reset state, with both requests pending.
        repeat (2) @(negedge clk);
        check("rst_if_ready", b1.if_req_ready, 0);
        check("rst_ls_ready", b1.ls_req_ready, 0);
        check("rst_mem_we", b1.mem_we, 0);
        check("rst_mem_addr", b1.mem_addr, 64'd0);
        check("rst_mem_wdata", b1.mem_wdata, 64'd0);
        check("rst_if_resp_valid", b1.if_resp_valid, 0);
        check("rst_ls_resp_valid", b1.ls_resp_valid, 0);
        check("rst_ls_resp_data", b1.ls_resp_data, 64'd0);
        check("rst_if_resp_error", b1.if_resp_error, 0);
        b1.if_req_valid = 1'b0;
        b1.ls_req_valid = 1'b0;
        reset1 = 1'b1;
        reset3 = 1'b1;

        // Store then load at 0x40.
        w0 = we1;
        txn(1'b1, 1'b1, 64'h40, 64'h7B, d, e, lat);
        check("st_lat", lat, 3);
        check("st_err", e, 0);
        check("st_data", d, 64'd0);
        check("st_we_cycles", we1 - w0, 1);
        w0 = we1;
        txn(1'b1, 1'b0, 64'h40, 64'd0, d, e, lat);
        check("ld_data", d, 64'h7B);
        check("ld_err", e, 0);
        check("ld_lat", lat, 3);
        check("ld_we_cycles", we1 - w0, 0);

        // Misaligned accesses never reach RAM.
        w0 = we1;
        txn(1'b1, 1'b0, 64'h43, 64'd0, d, e, lat);
        check("mis_ld_err", e, 1);
        check("mis_ld_data", d, 64'd0);
        check("mis_ld_lat", lat, 2);
        check("mis_mem_addr", b1.mem_addr, 64'h40);
        txn(1'b1, 1'b1, 64'h41, 64'hDEAD, d, e, lat);
        check("mis_st_err", e, 1);
        check("mis_we_cycles", we1 - w0, 0);
        txn(1'b0, 1'b0, 64'h40, 64'd0, d, e, lat);
        check("if_after_mis_data", d, 64'h7B);
        check("if_after_mis_err", e, 0);
        check("if_lat", lat, 3);

        // RAM-reported errors.
        txn(1'b1, 1'b0, 64'h10000, 64'd0, d, e, lat);
        check("ram_err_ls", e, 1);
        check("ram_err_ls_data", d, 64'd0);
        txn(1'b0, 1'b0, 64'h10000, 64'd0, d, e, lat);
        check("ram_err_if", e, 1);

        // Continuous contention straight out of reset.
        txn(1'b1, 1'b1, 64'h80, 64'h55, d, e, lat);
        @(negedge clk); reset1 = 1'b0;
        @(negedge clk); reset1 = 1'b1;
        @(posedge clk);
        #1;
        b1.ls_req_valid = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 64'h40;
        b1.if_req_valid = 1'b1; b1.if_addr = 64'h80;
        ri0 = if_resp1; rl0 = ls_resp1;
        n = 0; both = 0; bad = 0; dropped = 1'b0; gseq = 8'd0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b1.ls_resp_valid && b1.ls_resp_data !== 64'h7B) bad++;
            if (b1.if_resp_valid && b1.if_resp_data !== 64'h55) bad++;
            if (b1.ls_req_ready && b1.if_req_ready) both++;
            if (n < 8) begin
                if (b1.ls_req_ready) begin gseq[n] = 1'b1; n++; end
                else if (b1.if_req_ready) begin gseq[n] = 1'b0; n++; end
            end
            if (n == 8 && !dropped) begin
                @(posedge clk);
                #1;
                b1.ls_req_valid = 1'b0;
                b1.if_req_valid = 1'b0;
                dropped = 1'b1;
            end
        end
        check("rr_grants", n, 8);
        check("rr_sequence", gseq, 8'h55);
        check("rr_both_ready", both, 0);
        check("rr_if_resps", if_resp1 - ri0, 4);
        check("rr_ls_resps", ls_resp1 - rl0, 4);
        check("rr_resp_data", bad, 0);

        // Asynchronous reset in the middle of a store.
        txn(1'b1, 1'b1, 64'h100, 64'hAAAA, d, e, lat);
        @(posedge clk);
        #1;
        b1.ls_req_valid = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 64'h100; b1.ls_wdata = 64'h5555;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b1.ls_req_ready;
        end
        check("ar_ready", ok, 1);
        @(posedge clk);
        #1;
        b1.ls_req_valid = 1'b0;
        check("ar_we_in_access", b1.mem_we, 1);
        rl0 = ls_resp1;
        #2;
        reset1 = 1'b0;
        #1;
        check("ar_we_dropped", b1.mem_we, 0);
        repeat (3) @(negedge clk);
        reset1 = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_no_resp", ls_resp1 - rl0, 0);
        txn(1'b1, 1'b0, 64'h100, 64'd0, d, e, lat);
        check("ar_prior_data", d, 64'hAAAA);

        // MEM_LAT = 3 instance.
        @(posedge clk);
        #1;
        b3.ls_req_valid = 1'b1; b3.ls_we = 1'b1; b3.ls_addr = 64'h80; b3.ls_wdata = 64'h1234;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = b3.ls_req_ready; end
        check("l3_st_ready", ok, 1);
        @(posedge clk);
        #1;
        b3.ls_req_valid = 1'b0;
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b3.ls_resp_valid;
            if (!ok) begin @(posedge clk); lat++; end
        end
        check("l3_st_lat", lat, 5);
        check("l3_st_err", b3.ls_resp_error, 0);
        @(posedge clk);
        #1;
        b3.if_req_valid = 1'b1; b3.if_addr = 64'h80;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = b3.if_req_ready; end
        check("l3_if_ready", ok, 1);
        @(posedge clk);
        #1;
        b3.if_req_valid = 1'b0;
        b3.ls_req_valid = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 64'h80;
        lat = 1; ok = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b3.if_resp_valid;
            if (!ok) begin
                seen = seen | b3.if_req_ready | b3.ls_req_ready;
                @(posedge clk);
                lat++;
            end
        end
        check("l3_if_lat", lat, 5);
        check("l3_if_data", b3.if_resp_data, 64'h1234);
        check("l3_if_err", b3.if_resp_error, 0);
        check("l3_ready_low", seen, 0);
        check("l3_ls_granted", b3.ls_req_ready, 1);
        @(posedge clk);
        #1;
        b3.ls_req_valid = 1'b0;
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b3.ls_resp_valid;
            if (!ok) begin @(posedge clk); lat++; end
        end
        check("l3_ld_lat", lat, 5);
        check("l3_ld_data", b3.ls_resp_data, 64'h1234);

        // Bulk write/read of 1024 words with interleaved fetches.
        for (int i = 0; i < 1024; i++) begin
            txn(1'b1, 1'b1, 64'(i * 8), 64'(i * 333 + 123), d, e, lat);
        end
        bulk_err = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            txn(1'b1, 1'b0, 64'(i * 8), 64'd0, d, e, lat);
            check("bulk_ld", d, 64'(i * 333 + 123));
            bulk_err = bulk_err | e;
            if (i % 64 == 0) begin
                txn(1'b0, 1'b0, 64'(i * 8), 64'd0, d, e, lat);
                check("bulk_if", d, 64'(i * 333 + 123));
                bulk_err = bulk_err | e;
            end
        end
        check("bulk_err", bulk_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single read/write port of the `ram` block between two requesters:
  - instruction fetch (IF)
  - load/store unit (LS)
- Each requester uses a valid/ready request handshake and gets a one-cycle response pulse.
- Two-requester round-robin arbitration, at most one transaction outstanding.
- Sits between the core pipeline and `ram`. Allows a single-ported memory model in place of the dual-port `r_*`/`rw_*` usage.

Parameters:
- ADDR_WIDTH, 64: byte address width.
- DATA_WIDTH, 64: data word width; accesses are DATA_WIDTH/8-byte aligned.
- MEM_LAT, 1: cycles from the RAM access cycle until `mem_rdata`/`mem_error` are sampled; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_resp_valid  out  1  one-cycle fetch response pulse.
- if_resp_data  out  DATA_WIDTH  fetched word.
- if_resp_error  out  1  fetch error (misaligned or RAM error).
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store byte address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_resp_valid  out  1  one-cycle load/store response pulse (loads and stores).
- ls_resp_data  out  DATA_WIDTH  load data; 0 for stores.
- ls_resp_error  out  1  load/store error.
- mem_addr  out  ADDR_WIDTH  to `ram` rw_addr.
- mem_wdata  out  DATA_WIDTH  to `ram` rw_data_in.
- mem_we  out  1  to `ram` rw_write_en.
- mem_rdata  in  DATA_WIDTH  from `ram` rw_data_out.
- mem_error  in  1  from `ram` rw_error.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=IF, wait counter=0.
  - All outputs 0: ready, resp_valid, resp_data, resp_error, mem_addr, mem_wdata, mem_we.
  - Reset mid-transaction aborts it with no response. `mem_we` drops immediately, so there is no partial write.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Grant one requester: if only one valid, grant it; if both valid, grant the one not equal to last_grant. Out of reset, a tie grants LS.
  - Assert the granted *_req_ready combinationally in the same cycle; handshake = valid & ready.
  - Latch addr, we and wdata, and set last_grant.
  - If the granted address has its low log2(DATA_WIDTH/8) bits nonzero, go to RESP with error=1 and data=0; RAM is not touched.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive mem_addr/mem_wdata from the latched registers.
  - mem_we = latched we for exactly this one cycle (IF is always we=0).
  - Load counter with MEM_LAT-1. Go to WAIT if MEM_LAT>1, else RESP.
- WAIT: decrement the counter; go to RESP at 0. mem_addr is held stable, mem_we=0.
- RESP:
  - Register mem_rdata and mem_error into the granted requester's resp_data/resp_error.
  - Pulse its resp_valid for one cycle, then return to IDLE.
  - For stores, resp_data=0 and error=mem_error.
- Response registers hold their value until the next response to the same requester. The non-granted resp_valid stays 0.
- Ready is 0 in every state except IDLE; requesters must hold valid and payload until ready.
- No response backpressure: requesters must accept resp_valid pulses.
- Throughput: one transaction every MEM_LAT+2 cycles; request-to-response = MEM_LAT+2 edges.
- Simultaneous IF and LS requests alternate strictly under continuous contention, so neither starves.
- Address arithmetic: no wrap checking; the address is passed to RAM unmodified.

Decomposition:
- Package mem_arbiter_pkg:
  - state enum {IDLE, ACCESS, WAIT, RESP}
  - requester enum {REQ_IF, REQ_LS}
  - localparam BYTE_OFF_BITS = $clog2(DATA_WIDTH/8)
- Sub-module rr_arb2: two-input round-robin grant with last_grant register, enable and async active-low reset.

Test Plan:
- LS store addr 0x40, data 0x7B; then LS load 0x40 -> mem_we high exactly one cycle in ACCESS; load ls_resp_data=0x7B, error=0; response 3 edges after accept (MEM_LAT=1).
- IF and LS both valid every cycle for 8 transactions out of reset -> grants LS,IF,LS,IF,...; each requester receives 4 responses.
- LS load addr 0x43 -> ls_resp_error=1, data=0, mem_we never asserted, mem_addr unchanged; IF still served next.
- MEM_LAT=3: IF fetch 0x80 after storing 0x1234 there -> if_resp_valid 5 edges after accept with data 0x1234; ready low throughout.
- Assert reset=0 asynchronously during ACCESS of a store to 0x100 -> mem_we falls immediately, no resp_valid; a later load of 0x100 returns the prior contents.
- Write then read 1024 words (addr i*8, data i*333+123) via LS, IF fetch interleaved -> all 1024 compare, zero errors.
